sdram_read: RTL and testbench
=============================

SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 SHALL have parameter BURST_LEN, 32, Avalon words per read burst.
REQ-002 SHALL have parameter FRAME_BURSTS, 2048, bursts per frame (frame = FRAME_BURSTS*BURST_LEN 64-bit words).
REQ-003 SHALL have parameter FIFO_DEPTH, 256, internal output FIFO depth in words, power of two, >= 2*BURST_LEN.
REQ-004 SHALL have port clk_200  input  1  sole clock; all logic on rising edge; one clock domain.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_frame  input  1  one-cycle pulse starting a frame read.
REQ-007 SHALL have port reg_addr_buf_1  input  32  frame base address; bits [28:0] used.
REQ-008 SHALL have port avl_address  output  29  Avalon word address.
REQ-009 SHALL have port avl_read  output  1  Avalon read request.
REQ-010 SHALL have port avl_burstcount  output  8  burst length, constant BURST_LEN.
REQ-011 SHALL have port avl_byteenable  output  8  constant 8'hFF.
REQ-012 SHALL have port avl_waitrequest  input  1  slave stall.
REQ-013 SHALL have port avl_readdata  input  64  returned data.
REQ-014 SHALL have port avl_readdatavalid  input  1  returned-data qualifier.
REQ-015 SHALL have port data_ddr_out  output  64  pixel stream data.
REQ-016 SHALL have port valid_data_ddr_out  output  1  stream valid.
REQ-017 SHALL have port ready_in  input  1  consumer ready; word transfers when valid & ready.
REQ-018 SHALL have port busy  output  1  high from accepted start_frame until frame_done.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse after the last frame word leaves the stream.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-021 IDLE: on start_frame latch reg_addr_buf_1[28:0] into avl_address, clear burst counter, go ISSUE; busy rises next cycle.
REQ-022 ISSUE: assert avl_read only when FIFO free space minus outstanding words >= BURST_LEN (credit rule); FIFO SHALL never overflow.
REQ-023 Request accepted when avl_read & !avl_waitrequest; then avl_address += BURST_LEN (29-bit wrap), burst counter +1, outstanding += BURST_LEN.
REQ-024 While avl_waitrequest high, avl_read, avl_address, avl_burstcount SHALL stay stable.
REQ-025 Each avl_readdatavalid SHALL write avl_readdata into FIFO and decrement outstanding; acceptance and return in same cycle SHALL net correctly.
REQ-026 After FRAME_BURSTS-th accepted request go DRAIN; avl_read deasserts next cycle.
REQ-027 DRAIN: when outstanding == 0, FIFO empty and total words output == frame size, go DONE.
REQ-028 DONE: pulse frame_done one cycle, clear busy, return to IDLE.
REQ-029 Stream output SHALL be FIFO head, first-word-fall-through; valid_data_ddr_out = !fifo_empty; pop on valid & ready_in; ready_in low holds data stable.
REQ-030 Request-to-first-data latency is slave-defined; FIFO write-to-output latency SHALL be 1 cycle.
REQ-031 start_frame outside IDLE SHALL be ignored.
REQ-032 Outstanding counter width SHALL cover FIFO_DEPTH; output word counter SHALL cover frame size.
REQ-033 Word order on the stream SHALL equal ascending address order.

Reset
REQ-034 reset_n low SHALL force IDLE, avl_read=0, avl_address=0, avl_burstcount=BURST_LEN, busy=0, frame_done=0, valid_data_ddr_out=0, all counters 0, FIFO empty.
REQ-035 Reset mid-frame SHALL abandon the frame; readdatavalid arriving after reset release in IDLE SHALL be discarded.

Structure
REQ-036 BURST_LEN default, FSM state enum and address width constant SHALL live in shared package sdram_pkg.
REQ-037 FIFO SHALL be one sub-module sdram_read_fifo (single-clock, FWFT, full/empty/usedw).

Verification
REQ-038 Base 0x1000, FRAME_BURSTS=4, zero-wait slave, ready_in=1 -> requests at 0x1000,0x1020,0x1040,0x1060; 128 words in order; one frame_done.
REQ-039 ready_in held low 500 cycles -> at most FIFO_DEPTH words buffered, avl_read withheld, no data lost, resumes on release.
REQ-040 avl_waitrequest high 10 cycles on 2nd request -> address/read/burstcount stable, exactly 4 accepted requests.
REQ-041 start_frame during busy -> ignored, address sequence unchanged, single frame_done.
REQ-042 reset_n low after 2 bursts returned -> all outputs reset values; late readdatavalid ignored; fresh start_frame reads from new base correctly.
REQ-043 Base 0x1FFFFFE0, FRAME_BURSTS=2 -> second request at 0x00000000 (wrap).

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM frame reader: default burst size,
// Avalon address width, FSM state encoding and the burst address step.
package sdram_pkg;

  localparam int BURST_LEN_DEFAULT = 32;
  localparam int AVL_ADDR_W        = 29;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Next burst start address; wraps naturally at the Avalon address width.
  function automatic logic [AVL_ADDR_W-1:0] next_burst_addr(
    input logic [AVL_ADDR_W-1:0] addr,
    input int                    len
  );
    return addr + AVL_ADDR_W'(len);
  endfunction

endpackage

// File: rtl/sdram_read_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is always
// presented on rd_data; a write becomes visible one cycle later.
module sdram_read_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == {(AW+1){1'b0}});
  assign usedw   = count_r;
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array: written on every accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sdram_read.sv
// Frame reader: issues credit-limited Avalon read bursts over one frame
// and streams the returned words, in address order, through a FWFT FIFO.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int BURST_LEN    = BURST_LEN_DEFAULT,
  parameter int FRAME_BURSTS = 2048,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic                  clk_200,
  input  logic                  reset_n,
  input  logic                  start_frame,
  input  logic [31:0]           reg_addr_buf_1,
  output logic [AVL_ADDR_W-1:0] avl_address,
  output logic                  avl_read,
  output logic [7:0]            avl_burstcount,
  output logic [7:0]            avl_byteenable,
  input  logic                  avl_waitrequest,
  input  logic [63:0]           avl_readdata,
  input  logic                  avl_readdatavalid,
  output logic [63:0]           data_ddr_out,
  output logic                  valid_data_ddr_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FRAME_WORDS = FRAME_BURSTS * BURST_LEN;
  localparam int UW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = UW + 1;
  localparam int BCW = $clog2(FRAME_BURSTS + 1);
  localparam int WCW = $clog2(FRAME_WORDS + 1);

  state_t                state_r;
  state_t                state_s;
  logic [AVL_ADDR_W-1:0] addr_r;
  logic                  read_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  read_s;
  logic                  busy_s;
  logic                  done_s;
  logic [BCW-1:0]        burst_cnt_r;
  logic [UW-1:0]         outstanding_r;
  logic [WCW-1:0]        words_out_r;
  logic [UW-1:0]         usedw_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  accept_s;
  logic                  hold_s;
  logic                  active_s;
  logic                  wr_en_s;
  logic                  pop_s;
  logic                  last_burst_s;
  logic                  drained_s;
  logic [CW-1:0]         credit_s;
  logic [CW-1:0]         need_s;
  logic                  unused_s;

  assign accept_s     = read_r & ~avl_waitrequest;
  assign hold_s       = read_r & avl_waitrequest;
  assign active_s     = (state_r == ISSUE) || (state_r == DRAIN);
  // Returns are only accepted while a frame owns outstanding words, so
  // late data after a reset is dropped.
  assign wr_en_s      = avl_readdatavalid & active_s & (outstanding_r != {UW{1'b0}});
  assign pop_s        = ~fifo_empty_s & ready_in;
  assign last_burst_s = (burst_cnt_r == BCW'(FRAME_BURSTS - 1));
  assign drained_s    = (outstanding_r == {UW{1'b0}}) && fifo_empty_s &&
                        (words_out_r == WCW'(FRAME_WORDS));
  // Space not yet promised to any in-flight word.
  assign credit_s     = CW'(FIFO_DEPTH) - CW'(usedw_s) - CW'(outstanding_r);
  // A burst accepted this cycle consumes one burst of credit before the next.
  assign need_s       = accept_s ? CW'(2 * BURST_LEN) : CW'(BURST_LEN);

  assign avl_address        = addr_r;
  assign avl_read           = read_r;
  assign avl_burstcount     = 8'(BURST_LEN);
  assign avl_byteenable     = 8'hFF;
  assign valid_data_ddr_out = ~fifo_empty_s;
  assign busy               = busy_r;
  assign frame_done         = done_r;
  assign unused_s           = ^{reg_addr_buf_1[31:29], fifo_full_s};

  sdram_read_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_200),
    .rst_n   (reset_n),
    .wr_en   (wr_en_s),
    .wr_data (avl_readdata),
    .rd_en   (pop_s),
    .rd_data (data_ddr_out),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .usedw   (usedw_s)
  );

  // FSM state register.
  always_ff @(posedge clk_200 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_frame) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (accept_s && last_burst_s) state_s = DRAIN; else state_s = ISSUE;
      DRAIN:   if (drained_s) state_s = DONE; else state_s = DRAIN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode for the next cycle; a stalled request is held as is.
  always_comb begin
    read_s = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ISSUE: begin
        busy_s = 1'b1;
        if (hold_s) begin
          read_s = 1'b1;
        end else if (credit_s >= need_s) begin
          read_s = 1'b1;
        end else begin
          read_s = 1'b0;
        end
      end
      DRAIN:   busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk_200 or negedge reset_n) begin
    if (!reset_n) begin
      read_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      read_r <= read_s;
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Address, burst, in-flight and delivered-word counters.
  always_ff @(posedge clk_200 or negedge reset_n) begin
    if (!reset_n) begin
      addr_r        <= {AVL_ADDR_W{1'b0}};
      burst_cnt_r   <= {BCW{1'b0}};
      outstanding_r <= {UW{1'b0}};
      words_out_r   <= {WCW{1'b0}};
    end else begin
      if ((state_r == IDLE) && start_frame) begin
        addr_r      <= reg_addr_buf_1[AVL_ADDR_W-1:0];
        burst_cnt_r <= {BCW{1'b0}};
        words_out_r <= {WCW{1'b0}};
      end else begin
        if (accept_s) begin
          addr_r      <= next_burst_addr(addr_r, BURST_LEN);
          burst_cnt_r <= burst_cnt_r + BCW'(1);
        end
        if (pop_s) begin
          words_out_r <= words_out_r + WCW'(1);
        end
      end
      case ({accept_s, wr_en_s})
        2'b10:   outstanding_r <= outstanding_r + UW'(BURST_LEN);
        2'b01:   outstanding_r <= outstanding_r - UW'(1);
        2'b11:   outstanding_r <= outstanding_r + UW'(BURST_LEN - 1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_read.sv
// Testbench for sdram_read: randomized Avalon slave and stream consumer,
// checked against a frame model (ascending addresses, burst-aligned requests).
module tb_sdram_read;

  localparam int BL = 32;
  localparam int FB = 4;
  localparam int FD = 64;
  localparam int FW = BL * FB;

  logic        clk_200 = 1'b0;
  logic        reset_n;
  logic        start_frame;
  logic [31:0] reg_addr_buf_1;
  logic [28:0] avl_address;
  logic        avl_read;
  logic [7:0]  avl_burstcount;
  logic [7:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [63:0] avl_readdata;
  logic        avl_readdatavalid;
  logic [63:0] data_ddr_out;
  logic        valid_data_ddr_out;
  logic        ready_in;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int passed = 0;

  logic [31:0] key;
  logic [28:0] req_q[$];
  logic [28:0] pend_q[$];
  logic [63:0] stream_q[$];
  int delivered = 0;
  int popped = 0;
  int max_buf = 0;
  int done_cnt = 0;
  int stall_target = 0;
  int stall_len = 0;
  int stall_done = 0;
  int stall_bad = 0;
  int rdv_pct = 100;
  int ready_mode = 0;
  bit rdv_enable = 1'b1;
  logic [28:0] stall_addr;

  always #5 clk_200 = ~clk_200;

  sdram_read #(
    .BURST_LEN    (BL),
    .FRAME_BURSTS (FB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk_200            (clk_200),
    .reset_n            (reset_n),
    .start_frame        (start_frame),
    .reg_addr_buf_1     (reg_addr_buf_1),
    .avl_address        (avl_address),
    .avl_read           (avl_read),
    .avl_burstcount     (avl_burstcount),
    .avl_byteenable     (avl_byteenable),
    .avl_waitrequest    (avl_waitrequest),
    .avl_readdata       (avl_readdata),
    .avl_readdatavalid  (avl_readdatavalid),
    .data_ddr_out       (data_ddr_out),
    .valid_data_ddr_out (valid_data_ddr_out),
    .ready_in           (ready_in),
    .busy               (busy),
    .frame_done         (frame_done)
  );

  // Avalon slave + stream consumer, acting mid-cycle for the next rising edge.
  task automatic slave_proc();
    logic [28:0] a;
    forever begin
      @(negedge clk_200);
      if (frame_done === 1'b1) done_cnt++;
      case (ready_mode)
        0:       ready_in = 1'b1;
        1:       ready_in = ($urandom_range(0, 1) == 1);
        default: ready_in = 1'b0;
      endcase
      if (valid_data_ddr_out === 1'b1 && ready_in === 1'b1) begin
        stream_q.push_back(data_ddr_out);
        popped++;
      end
      if (pend_q.size() > 0 && rdv_enable && $urandom_range(1, 100) <= rdv_pct) begin
        a = pend_q.pop_front();
        avl_readdata = {key, 3'b000, a};
        avl_readdatavalid = 1'b1;
        delivered++;
      end else begin
        avl_readdata = {$urandom(), $urandom()};
        avl_readdatavalid = 1'b0;
      end
      avl_waitrequest = 1'b0;
      if (stall_target != 0 && req_q.size() == stall_target - 1 && stall_done > 0 &&
          stall_done < stall_len && avl_read !== 1'b1) stall_bad++;
      if (avl_read === 1'b1) begin
        if (stall_target != 0 && req_q.size() == stall_target - 1 && stall_done < stall_len) begin
          if (stall_done == 0) stall_addr = avl_address;
          else if (avl_address !== stall_addr || avl_burstcount !== 8'd32) stall_bad++;
          avl_waitrequest = 1'b1;
          stall_done++;
        end else begin
          if (stall_target != 0 && req_q.size() == stall_target - 1 && avl_address !== stall_addr)
            stall_bad++;
          req_q.push_back(avl_address);
          for (int i = 0; i < BL; i++) pend_q.push_back(avl_address + 29'(i));
        end
      end
      if (delivered - popped > max_buf) max_buf = delivered - popped;
    end
  endtask

  // Reference: requests must be consecutive burst-aligned steps from the base.
  function automatic int req_errors(input logic [31:0] base);
    int e = 0;
    logic [28:0] a = base[28:0];
    if (req_q.size() != FB) e++;
    for (int i = 0; i < FB && i < req_q.size(); i++) begin
      if (req_q[i] !== a) e++;
      a = a + 29'(BL);
    end
    return e;
  endfunction

  // Reference: the stream is every frame word in ascending address order.
  function automatic int stream_errors(input logic [31:0] base);
    int e = 0;
    logic [28:0] a = base[28:0];
    if (stream_q.size() != FW) e++;
    for (int i = 0; i < FW && i < stream_q.size(); i++) begin
      if (stream_q[i] !== {key, 3'b000, a}) e++;
      a = a + 29'd1;
    end
    return e;
  endfunction

  task automatic clear_model();
    req_q.delete(); pend_q.delete(); stream_q.delete();
    delivered = 0; popped = 0; max_buf = 0; done_cnt = 0;
    stall_target = 0; stall_len = 0; stall_done = 0; stall_bad = 0;
    key = $urandom();
  endtask

  task automatic pulse_start(input logic [31:0] base);
    @(negedge clk_200);
    start_frame = 1'b1;
    reg_addr_buf_1 = base;
    @(negedge clk_200);
    start_frame = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk_200);
      n++;
    end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_200);
    checks++; if (avl_read !== 1'b0) $display("FAIL reset_read: got %b want 0", avl_read); else passed++;
    checks++; if (avl_address !== 29'h0) $display("FAIL reset_addr: got %h want 0", avl_address); else passed++;
    checks++; if (avl_burstcount !== 8'd32) $display("FAIL reset_burstcount: got %0d want 32", avl_burstcount); else passed++;
    checks++; if (avl_byteenable !== 8'hFF) $display("FAIL byteenable: got %h want ff", avl_byteenable); else passed++;
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy, frame_done); else passed++;
    checks++; if (valid_data_ddr_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_data_ddr_out); else passed++;
    @(negedge clk_200);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_200);
    checks++; if (busy !== 1'b0 || avl_read !== 1'b0) $display("FAIL idle_after_reset: busy %b read %b want 0 0", busy, avl_read); else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    int e;
    clear_model(); rdv_pct = 100; ready_mode = 0;
    pulse_start(32'h0000_1000);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", busy); else passed++;
    wait_done(2000, ok);
    checks++; if (!ok) $display("FAIL basic_timeout: got no frame_done want one"); else passed++;
    e = req_errors(32'h0000_1000);
    checks++; if (e != 0) $display("FAIL basic_requests: got %0d bad of %0d want 0", e, req_q.size()); else passed++;
    e = stream_errors(32'h0000_1000);
    checks++; if (e != 0) $display("FAIL basic_stream: got %0d bad, %0d words want 0 bad, %0d", e, stream_q.size(), FW); else passed++;
    repeat (3) @(negedge clk_200);
    checks++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", busy); else passed++;
  endtask

  task automatic test_random();
    bit ok;
    int e;
    logic [31:0] base;
    for (int t = 0; t < 3; t++) begin
      clear_model(); base = $urandom(); rdv_pct = $urandom_range(20, 100); ready_mode = 1;
      pulse_start(base);
      wait_done(6000, ok);
      checks++; if (!ok) $display("FAIL random_timeout[%0d]: got no frame_done want one", t); else passed++;
      e = req_errors(base) + stream_errors(base);
      checks++; if (e != 0) $display("FAIL random_frame[%0d]: got %0d errors want 0 (base %h)", t, e, base); else passed++;
      checks++; if (max_buf > FD) $display("FAIL random_overflow[%0d]: got %0d buffered want <= %0d", t, max_buf, FD); else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int e;
    logic [31:0] base;
    clear_model(); base = $urandom(); rdv_pct = 100; ready_mode = 2;
    pulse_start(base);
    repeat (500) @(negedge clk_200);
    checks++; if (delivered - popped != FD) $display("FAIL bp_buffered: got %0d want %0d", delivered - popped, FD); else passed++;
    checks++; if (req_q.size() != 2) $display("FAIL bp_requests: got %0d want 2", req_q.size()); else passed++;
    checks++; if (avl_read !== 1'b0) $display("FAIL bp_read_withheld: got %b want 0", avl_read); else passed++;
    checks++; if (valid_data_ddr_out !== 1'b1 || data_ddr_out !== {key, 3'b000, base[28:0]})
      $display("FAIL bp_head: got %b %h want 1 %h", valid_data_ddr_out, data_ddr_out, {key, 3'b000, base[28:0]}); else passed++;
    ready_mode = 0;
    wait_done(2000, ok);
    checks++; if (!ok) $display("FAIL bp_timeout: got no frame_done want one"); else passed++;
    e = req_errors(base) + stream_errors(base);
    checks++; if (e != 0) $display("FAIL bp_frame: got %0d errors want 0", e); else passed++;
    checks++; if (max_buf > FD) $display("FAIL bp_overflow: got %0d buffered want <= %0d", max_buf, FD); else passed++;
  endtask

  task automatic test_waitrequest();
    bit ok;
    int e;
    logic [31:0] base;
    clear_model(); base = $urandom(); rdv_pct = 100; ready_mode = 0;
    stall_target = 2; stall_len = 10;
    pulse_start(base);
    wait_done(2000, ok);
    checks++; if (!ok) $display("FAIL wr_timeout: got no frame_done want one"); else passed++;
    checks++; if (stall_done != 10) $display("FAIL wr_stall_cycles: got %0d want 10", stall_done); else passed++;
    checks++; if (stall_bad != 0) $display("FAIL wr_stable: got %0d unstable cycles want 0", stall_bad); else passed++;
    e = req_errors(base) + stream_errors(base);
    checks++; if (e != 0) $display("FAIL wr_frame: got %0d errors want 0", e); else passed++;
    stall_target = 0;
  endtask

  task automatic test_start_ignored();
    bit ok;
    int e;
    logic [31:0] base;
    clear_model(); base = $urandom(); rdv_pct = 70; ready_mode = 1;
    pulse_start(base);
    repeat (20) @(negedge clk_200);
    checks++; if (busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", busy); else passed++;
    pulse_start(~base);
    wait_done(6000, ok);
    checks++; if (!ok) $display("FAIL ign_timeout: got no frame_done want one"); else passed++;
    e = req_errors(base) + stream_errors(base);
    checks++; if (e != 0) $display("FAIL ign_frame: got %0d errors want 0", e); else passed++;
    repeat (40) @(negedge clk_200);
    checks++; if (done_cnt != 1 || req_q.size() != FB) $display("FAIL ign_single: got %0d done %0d reqs want 1 %0d", done_cnt, req_q.size(), FB); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL ign_idle: got busy %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int e;
    int n = 0;
    logic [31:0] base;
    clear_model(); base = $urandom(); rdv_pct = 100; ready_mode = 2;
    pulse_start(base);
    while (delivered < 2 * BL && n < 500) begin @(negedge clk_200); n++; end
    checks++; if (delivered < 2 * BL) $display("FAIL mid_two_bursts: got %0d words want %0d", delivered, 2 * BL); else passed++;
    @(negedge clk_200);
    reset_n = 1'b0; rdv_enable = 1'b0;
    @(negedge clk_200);
    checks++; if (avl_read !== 1'b0 || avl_address !== 29'h0 || avl_burstcount !== 8'd32)
      $display("FAIL mid_reset_avl: got %b %h %0d want 0 0 32", avl_read, avl_address, avl_burstcount); else passed++;
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || valid_data_ddr_out !== 1'b0)
      $display("FAIL mid_reset_outs: got %b%b%b want 000", busy, frame_done, valid_data_ddr_out); else passed++;
    for (int i = 0; i < 8; i++) pend_q.push_back(base[28:0] + 29'(i));
    ready_mode = 0;
    @(negedge clk_200);
    reset_n = 1'b1; rdv_enable = 1'b1; stream_q.delete();
    repeat (30) @(negedge clk_200);
    checks++; if (stream_q.size() != 0 || valid_data_ddr_out !== 1'b0)
      $display("FAIL mid_late_data: got %0d words valid %b want 0 0", stream_q.size(), valid_data_ddr_out); else passed++;
    checks++; if (busy !== 1'b0 || avl_read !== 1'b0) $display("FAIL mid_idle: got busy %b read %b want 0 0", busy, avl_read); else passed++;
    clear_model(); base = $urandom(); rdv_pct = 100; ready_mode = 0;
    pulse_start(base);
    wait_done(2000, ok);
    checks++; if (!ok) $display("FAIL mid_restart_timeout: got no frame_done want one"); else passed++;
    e = req_errors(base) + stream_errors(base);
    checks++; if (e != 0) $display("FAIL mid_restart_frame: got %0d errors want 0", e); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    int e;
    logic [28:0] second;
    clear_model(); rdv_pct = 100; ready_mode = 0;
    pulse_start(32'h1FFF_FFE0);
    wait_done(2000, ok);
    checks++; if (!ok) $display("FAIL wrap_timeout: got no frame_done want one"); else passed++;
    second = (req_q.size() > 1) ? req_q[1] : 29'h1FFF_FFFF;
    checks++; if (second !== 29'h0) $display("FAIL wrap_second_req: got %h want 0", second); else passed++;
    e = req_errors(32'h1FFF_FFE0) + stream_errors(32'h1FFF_FFE0);
    checks++; if (e != 0) $display("FAIL wrap_frame: got %0d errors want 0", e); else passed++;
  endtask

  initial begin
    reset_n = 1'b0; start_frame = 1'b0; reg_addr_buf_1 = 32'h0;
    avl_waitrequest = 1'b0; avl_readdata = 64'h0; avl_readdatavalid = 1'b0; ready_in = 1'b1;
    fork
      slave_proc();
    join_none
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_waitrequest();
    test_start_ignored();
    test_reset_midframe();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
